// File: rtl/ex_mem_if.sv
// EX->MEM bundle: valid/ready handshake plus the control and data fields carried to the MEM stage.
// The master drives valid and payload; the slave drives ready.
interface ex_mem_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int SRC_W  = 2
);
   logic              valid;
   logic              ready;
   logic              reg_we;
   logic              mem_we;
   logic [REG_AW-1:0] wr_addr;
   logic [SRC_W-1:0]  reg_src;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] jal_tgt;
   logic [DATA_W-1:0] pc;

   modport master (
      output valid, reg_we, mem_we, wr_addr, reg_src, alu_out, wr_data, jal_tgt, pc,
      input  ready
   );

   modport slave (
      input  valid, reg_we, mem_we, wr_addr, reg_src, alu_out, wr_data, jal_tgt, pc,
      output ready
   );
endinterface

// File: rtl/ex_mem_elastic.sv
// Elastic EX->MEM pipeline register: OUT register plus one skid entry, flush, bubble write gating.
// Optional stall/bubble performance counters when EX_MEM_PERF_EN is defined.
module ex_mem_elastic #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int SRC_W       = 2,
   parameter bit SUPPRESS_R0 = 1'b1
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     flush_i,
   ex_mem_if.slave  e_if,
   ex_mem_if.master m_if
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] bubble_cnt_o
`endif
);

   typedef struct packed {
      logic              reg_we;
      logic              mem_we;
      logic [REG_AW-1:0] wr_addr;
      logic [SRC_W-1:0]  reg_src;
      logic [DATA_W-1:0] alu_out;
      logic [DATA_W-1:0] wr_data;
      logic [DATA_W-1:0] jal_tgt;
      logic [DATA_W-1:0] pc;
   } bundle_t;

   bundle_t out_q, out_d, skid_q, skid_d, in_b;
   logic    out_v_q, out_v_d, skid_v_q, skid_v_d;
   logic    acc, del;

   always_comb begin
      in_b.reg_we  = e_if.reg_we & (!SUPPRESS_R0 || (e_if.wr_addr != '0));
      in_b.mem_we  = e_if.mem_we;
      in_b.wr_addr = e_if.wr_addr;
      in_b.reg_src = e_if.reg_src;
      in_b.alu_out = e_if.alu_out;
      in_b.wr_data = e_if.wr_data;
      in_b.jal_tgt = e_if.jal_tgt;
      in_b.pc      = e_if.pc;
   end

   assign acc = e_if.valid & ~skid_v_q & ~flush_i;
   assign del = out_v_q & m_if.ready;

   always_comb begin
      out_d    = out_q;
      skid_d   = skid_q;
      out_v_d  = out_v_q;
      skid_v_d = skid_v_q;
      if (flush_i) begin
         out_v_d  = 1'b0;
         skid_v_d = 1'b0;
      end else if (!out_v_q || del) begin
         // A held skid entry always drains first; input cannot be accepted then.
         if (skid_v_q) begin
            out_d    = skid_q;
            out_v_d  = 1'b1;
            skid_v_d = 1'b0;
         end else begin
            if (acc) out_d = in_b;
            out_v_d = acc;
         end
      end else if (acc) begin
         skid_d   = in_b;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         out_q    <= out_d;
         skid_q   <= skid_d;
         out_v_q  <= out_v_d;
         skid_v_q <= skid_v_d;
      end
   end

   assign e_if.ready   = ~skid_v_q;
   assign m_if.valid   = out_v_q;
   assign m_if.reg_we  = out_q.reg_we & out_v_q;
   assign m_if.mem_we  = out_q.mem_we & out_v_q;
   assign m_if.wr_addr = out_q.wr_addr;
   assign m_if.reg_src = out_q.reg_src;
   assign m_if.alu_out = out_q.alu_out;
   assign m_if.wr_data = out_q.wr_data;
   assign m_if.jal_tgt = out_q.jal_tgt;
   assign m_if.pc      = out_q.pc;

`ifdef EX_MEM_PERF_EN
   logic [31:0] stall_cnt_q, bubble_cnt_q;

   // Counters are observability only; flush does not clear them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (out_v_q && !m_if.ready) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (!out_v_q) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
